decode_pipe: RTL
================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Param DATA_W, 32, datapath width for operands, pc and immediate; legal 16..64.
REQ-002 Param NUM_REGS, 32, number of architectural registers; legal 2..32.
REQ-003 Param BYPASS_EN, 1, same-cycle writeback-to-read forwarding enable.
REQ-004 Param SKID_EN, 1, selects a 2-entry skid output (1) or a single output register (0).
REQ-005 Param CNT_W, 16, width of the performance counters.
REQ-006 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 in_valid_i / in_ready_o  in/out  1/1  upstream instruction handshake.
REQ-009 instr_i  in  32  instruction word.
REQ-010 pc_i  in  DATA_W  pc of instr_i.
REQ-011 flush_i  in  1  discard every held and incoming instruction.
REQ-012 wb_en_i, wb_sel_i, wb_data_i  in  1, 5, DATA_W  register-file write port.
REQ-013 out_valid_o / out_ready_i  out/in  1/1  downstream handshake.
REQ-014 out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o  out  DATA_W each  decoded operands.
REQ-015 out_rd_o, out_rs1_o, out_rs2_o, out_row_o, out_col_o  out  5 each  register and TPU fields.
REQ-016 out_ctrl_o  out  15  control bundle {alu_op[3:0], wb_sel[1:0], branch_type[1:0], imm_sel, reg_we, mem_we, tpu_start, tpu_we_A, tpu_we_B, tpu_we_C}, MSB first.
REQ-017 cnt_clr_i  in  1  clears both counters.
REQ-018 stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-019 Fields: op=instr[31:25], rd=[24:20], rs1=[19:15], rs2=[14:10], row=[17:13], col=[12:8]; control bundle decoded from op by the existing control unit.
REQ-020 Immediate: branch_type[0] ? {instr[24:20],instr[9:0]} : instr[14:0], sign-extended from bit 14 to DATA_W.
REQ-021 Register file: NUM_REGS x DATA_W; asynchronous read; write on clock edge when wb_en_i=1 and wb_sel_i<NUM_REGS; indices >=NUM_REGS read 0 and ignore writes.
REQ-022 BYPASS_EN=1: when wb_en_i=1 and wb_sel_i equals rs1/rs2 (<NUM_REGS), that operand takes wb_data_i in the same cycle; BYPASS_EN=0: old value.
REQ-023 Accept = in_valid_i & in_ready_o & !flush_i; operands are captured at accept and never refreshed afterwards.
REQ-024 Latency: accepted instruction appears with out_valid_o=1 on the next cycle when the output stage is empty or draining.
REQ-025 SKID_EN=1: in_ready_o = !skid_valid, registered; if the main slot is held (out_valid_o=1, out_ready_i=0) and accept occurs, the instruction goes to the skid slot.
REQ-026 SKID_EN=1: when the main slot drains or is empty, it loads from the skid slot if valid, otherwise from the accepted instruction; order is strictly preserved.
REQ-027 SKID_EN=0: in_ready_o = !out_valid_o | out_ready_i, combinational.
REQ-028 Held outputs remain stable while out_valid_o=1 and out_ready_i=0.
REQ-029 out_ctrl_o is forced to all-zero whenever out_valid_o=0; other data outputs hold their last value.
REQ-030 Flush: next cycle both slots are invalid and the incoming instruction is dropped; a same-cycle output handshake still counts as completed.
REQ-031 stall_cnt_o increments each cycle with in_valid_i=1, in_ready_o=0, flush_i=0; flush_cnt_o increments each cycle with flush_i=1; both saturate at all-ones.
REQ-032 cnt_clr_i zeroes both counters next cycle and overrides increments.

Reset
REQ-033 With rst_i=1 at a clock edge: both slots invalid, all outputs and counters zero, and all registers zero; reset overrides flush_i, cnt_clr_i and writeback; in_ready_o=1 in the first cycle after reset.

Verification
REQ-034 Reset, write r3=0x12345678, decode rs1=3 with out_ready_i=1 -> out_rs1_data_o=0x12345678 one cycle after accept.
REQ-035 wb_en_i=1, wb_sel_i=4, wb_data_i=0xA5 in the cycle that accepts rs2=4 -> out_rs2_data_o=0xA5 (BYPASS_EN=1); 0 (BYPASS_EN=0).
REQ-036 SKID_EN=1, out_ready_i=0, feed I0,I1,I2 back-to-back -> I0 held, I1 skidded, in_ready_o=0, stall_cnt_o=1; release -> I0,I1,I2 emitted in order with no loss.
REQ-037 Two held instructions plus flush_i=1 for 1 cycle -> out_valid_o=0, out_ctrl_o=0, flush_cnt_o=1, next instruction decodes normally.
REQ-038 Branch instr with instr[24:20]=5'b10000 -> out_imm_o sign-extended negative (0xFFFFC000 | instr[9:0] at DATA_W=32).
REQ-039 Hold stall for 2^CNT_W+3 cycles -> stall_cnt_o saturates at all-ones; cnt_clr_i=1 -> 0.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with register file, writeback
// forwarding, a one- or two-entry output buffer and stall/flush counters.
module decode_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_EN = 1,
  parameter int SKID_EN   = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [4:0]        wb_sel_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_pc_o,
  output logic [DATA_W-1:0] out_rs1_data_o,
  output logic [DATA_W-1:0] out_rs2_data_o,
  output logic [DATA_W-1:0] out_imm_o,
  output logic [4:0]        out_rd_o,
  output logic [4:0]        out_rs1_o,
  output logic [4:0]        out_rs2_o,
  output logic [4:0]        out_row_o,
  output logic [4:0]        out_col_o,
  output logic [14:0]       out_ctrl_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Opcode map of the control unit
  localparam logic [6:0] OP_ADD   = 7'h01;
  localparam logic [6:0] OP_SUB   = 7'h02;
  localparam logic [6:0] OP_AND   = 7'h03;
  localparam logic [6:0] OP_OR    = 7'h04;
  localparam logic [6:0] OP_XOR   = 7'h05;
  localparam logic [6:0] OP_ADDI  = 7'h06;
  localparam logic [6:0] OP_LOAD  = 7'h07;
  localparam logic [6:0] OP_STORE = 7'h08;
  localparam logic [6:0] OP_BEQ   = 7'h09;
  localparam logic [6:0] OP_BNE   = 7'h0A;
  localparam logic [6:0] OP_JAL   = 7'h0B;
  localparam logic [6:0] OP_TSTRT = 7'h10;
  localparam logic [6:0] OP_TWA   = 7'h11;
  localparam logic [6:0] OP_TWB   = 7'h12;
  localparam logic [6:0] OP_TWC   = 7'h13;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        row;
    logic [4:0]        col;
    logic [14:0]       ctrl;
  } slot_t;

  // ---------------- register file ----------------
  // A 32-entry read view is built so any 5-bit index can be used directly;
  // entries beyond NUM_REGS read zero and have no storage.
  logic [DATA_W-1:0] rd_vec [32];
  logic [31:0]       reg_exists;

  for (genvar gi = 0; gi < 32; gi++) begin : g_rf
    if (gi < NUM_REGS) begin : g_reg
      logic [DATA_W-1:0] r_q;
      // Register write on a matching writeback
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_q <= '0;
        end else if (wb_en_i && (wb_sel_i == 5'(gi))) begin
          r_q <= wb_data_i;
        end
      end
      assign rd_vec[gi]     = r_q;
      assign reg_exists[gi] = 1'b1;
    end else begin : g_none
      assign rd_vec[gi]     = '0;
      assign reg_exists[gi] = 1'b0;
    end
  end

  // ---------------- decode ----------------
  logic [6:0]  op;
  logic [3:0]  alu_op;
  logic [1:0]  wbs, br_type;
  logic        imm_sel, reg_we, mem_we, tpu_start, tpu_wa, tpu_wb, tpu_wc;
  logic [14:0] imm15;
  logic        byp1, byp2;
  slot_t       dec;

  assign op = instr_i[31:25];

  // Control unit: opcode to control bundle, unknown opcodes decode to zero
  always_comb begin
    alu_op = 4'd0; wbs = 2'd0; br_type = 2'd0; imm_sel = 1'b0;
    reg_we = 1'b0; mem_we = 1'b0; tpu_start = 1'b0;
    tpu_wa = 1'b0; tpu_wb = 1'b0; tpu_wc = 1'b0;
    case (op)
      OP_ADD:   reg_we = 1'b1;
      OP_SUB:   begin alu_op = 4'd1; reg_we = 1'b1; end
      OP_AND:   begin alu_op = 4'd2; reg_we = 1'b1; end
      OP_OR:    begin alu_op = 4'd3; reg_we = 1'b1; end
      OP_XOR:   begin alu_op = 4'd4; reg_we = 1'b1; end
      OP_ADDI:  begin imm_sel = 1'b1; reg_we = 1'b1; end
      OP_LOAD:  begin wbs = 2'd1; imm_sel = 1'b1; reg_we = 1'b1; end
      OP_STORE: begin imm_sel = 1'b1; mem_we = 1'b1; end
      OP_BEQ:   begin alu_op = 4'd1; br_type = 2'd1; end
      OP_BNE:   begin alu_op = 4'd1; br_type = 2'd3; end
      OP_JAL:   begin wbs = 2'd2; br_type = 2'd2; reg_we = 1'b1; end
      OP_TSTRT: tpu_start = 1'b1;
      OP_TWA:   tpu_wa = 1'b1;
      OP_TWB:   tpu_wb = 1'b1;
      OP_TWC:   tpu_wc = 1'b1;
      default:  ;
    endcase
  end

  // Branch immediates splice the rd field above the low ten bits
  assign imm15 = br_type[0] ? {instr_i[24:20], instr_i[9:0]} : instr_i[14:0];

  // Forwarding only for a write that actually lands in an existing register
  assign byp1 = (BYPASS_EN != 0) && wb_en_i && (wb_sel_i == instr_i[19:15]) && reg_exists[instr_i[19:15]];
  assign byp2 = (BYPASS_EN != 0) && wb_en_i && (wb_sel_i == instr_i[14:10]) && reg_exists[instr_i[14:10]];

  assign dec.pc       = pc_i;
  assign dec.rs1_data = byp1 ? wb_data_i : rd_vec[instr_i[19:15]];
  assign dec.rs2_data = byp2 ? wb_data_i : rd_vec[instr_i[14:10]];
  assign dec.imm      = {{(DATA_W-15){imm15[14]}}, imm15};
  assign dec.rd       = instr_i[24:20];
  assign dec.rs1      = instr_i[19:15];
  assign dec.rs2      = instr_i[14:10];
  assign dec.row      = instr_i[17:13];
  assign dec.col      = instr_i[12:8];
  assign dec.ctrl     = {alu_op, wbs, br_type, imm_sel, reg_we, mem_we,
                         tpu_start, tpu_wa, tpu_wb, tpu_wc};

  // ---------------- output buffer ----------------
  slot_t main_q, main_d, skid_q, skid_d;
  logic  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic  accept, drain;

  if (SKID_EN != 0) begin : g_rdy_skid
    assign in_ready_o = !skid_valid_q;
  end else begin : g_rdy_single
    assign in_ready_o = !main_valid_q || out_ready_i;
  end

  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign drain  = !main_valid_q || out_ready_i;

  // Slot next-state: skid entry always drains first so order is preserved
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // Slot registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o    = main_valid_q;
  assign out_pc_o       = main_q.pc;
  assign out_rs1_data_o = main_q.rs1_data;
  assign out_rs2_data_o = main_q.rs2_data;
  assign out_imm_o      = main_q.imm;
  assign out_rd_o       = main_q.rd;
  assign out_rs1_o      = main_q.rs1;
  assign out_rs2_o      = main_q.rs2;
  assign out_row_o      = main_q.row;
  assign out_col_o      = main_q.col;
  assign out_ctrl_o     = main_valid_q ? main_q.ctrl : 15'd0;

  // ---------------- performance counters ----------------
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc;

  assign stall_inc = in_valid_i && !in_ready_o && !flush_i;

  // Saturating counters; clear wins over increment
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_i && (flush_cnt_q != '1))   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
